multicycle_ctrl: RTL
====================

// Module: multicycle_ctrl
// PURPOSE
//   Moore FSM sequencing a shared-memory multi-cycle MIPS datapath for R-type, lw, sw, beq, bne, j, addi, andi.
//   Drives per-cycle enables and mux selects: PC, IR, register file, ALU, memory port.
//   Sits beside the datapath; consumes IR opcode and a memory-ready handshake.
//   Traps on illegal opcode or memory timeout.
// PARAMETERS
//   MEM_TIMEOUT  15  max wait cycles per memory access before trap; 0 = wait forever
//   CNT_W        4   width of wait counter; must satisfy 2**CNT_W > MEM_TIMEOUT
// PORTS
//   clk          in   1   single clock, rising edge
//   reset        in   1   asynchronous, active-high
//   opcode       in   6   IR[31:26], valid from DECODE onward
//   mem_ready    in   1   memory completes current access this cycle
//   mem_req      out  1   memory access request, held until mem_ready
//   mem_wr       out  1   access is a write (qualifies mem_req)
//   iord         out  1   0 = address from PC, 1 = address from ALUOut
//   ir_wr        out  1   load IR
//   pc_wr        out  1   unconditional PC write
//   pc_wr_beq    out  1   PC write if ALU zero
//   pc_wr_bne    out  1   PC write if not ALU zero
//   pc_src       out  2   00 = ALU result, 01 = ALUOut, 10 = jump target
//   alu_src_a    out  1   0 = PC, 1 = rs
//   alu_src_b    out  2   00 = rt, 01 = const 4, 10 = sign-ext imm, 11 = sign-ext imm<<2
//   alu_op       out  2   00 = add, 01 = sub, 10 = funct field, 11 = and
//   reg_wr       out  1   register file write
//   reg_dst      out  1   1 = rd, 0 = rt
//   mem2reg      out  1   0 = write memory data, 1 = write ALUOut
//   retire       out  1   one-cycle pulse on the final cycle of each instruction
//   trap         out  1   sticky; high in TRAP state
//   trap_cause   out  2   00 = none, 01 = illegal opcode, 10 = memory timeout
// BEHAVIOUR
//   Reset: state = IDLE, wait_cnt = 0, trap_cause = 00; every output 0 while in IDLE.
//   IDLE -> FETCH unconditionally on the first clock after reset deasserts.
//   Outputs decode from state only; exception: ir_wr and pc_wr in FETCH are gated by mem_ready.
//   FETCH: mem_req = 1, iord = 0, alu_src_a = 0, alu_src_b = 01, alu_op = 00, pc_src = 00.
//     On mem_ready: ir_wr = 1, pc_wr = 1, next state DECODE. Otherwise stay.
//   DECODE: alu_src_a = 0, alu_src_b = 11, alu_op = 00 (ALUOut = branch target).
//     Next state by opcode:
//       lw, sw -> MEM_ADDR; R-type -> R_EXEC; beq, bne -> BRANCH; j -> JUMP;
//       addi, andi -> I_EXEC; any other opcode -> TRAP (cause 01).
//   MEM_ADDR: alu_src_a = 1, alu_src_b = 10, alu_op = 00; next MEM_RD (lw) or MEM_WR (sw).
//   MEM_RD: mem_req = 1, iord = 1; on mem_ready -> MEM_WB.
//   MEM_WB: reg_wr = 1, reg_dst = 0, mem2reg = 0, retire = 1; next FETCH.
//   MEM_WR: mem_req = 1, mem_wr = 1, iord = 1; on mem_ready: retire = 1, next FETCH.
//   R_EXEC: alu_src_a = 1, alu_src_b = 00, alu_op = 10; next ALU_WB with reg_dst = 1.
//   I_EXEC: alu_src_a = 1, alu_src_b = 10, alu_op = 00 (addi) or 11 (andi); next ALU_WB with reg_dst = 0.
//   ALU_WB: reg_wr = 1, mem2reg = 1, retire = 1; reg_dst is held in a flag register; next FETCH.
//   BRANCH: alu_src_a = 1, alu_src_b = 00, alu_op = 01, pc_src = 01;
//     pc_wr_beq or pc_wr_bne per opcode; retire = 1; next FETCH.
//   JUMP: pc_src = 10, pc_wr = 1, retire = 1; next FETCH.
//   Wait counter:
//     Cleared on entry to any memory state; increments each cycle mem_req = 1 and mem_ready = 0.
//     If MEM_TIMEOUT != 0 and wait_cnt == MEM_TIMEOUT with mem_ready = 0: TRAP, cause 10.
//     mem_ready in the same cycle wins over timeout.
//   TRAP: all controls 0, trap = 1; only reset exits.
//   The memory handshake is never retracted: mem_req stays high, with address and write selects stable, until mem_ready.
//   mem_ready outside FETCH/MEM_RD/MEM_WR is ignored.
//   Reset mid-access: async return to IDLE; mem_req drops immediately.
//   opcode is sampled only in DECODE and BRANCH/I_EXEC; it is held stable by IR.
// STRUCTURE
//   Shared package mips_pkg:
//     opcode localparams (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J, OP_ADDI, OP_ANDI);
//     ALU_OP_* and state encodings (4-bit enum); trap cause codes.
//   Sub-module mem_wait_timer (counter + timeout compare) instantiated once.
//   Next-state logic and output decode are separate always blocks.
// TESTING
//   1. Reset, then lw (op 100011), mem_ready high 2 cycles after each req
//      -> states IDLE,FETCH(x3),DECODE,MEM_ADDR,MEM_RD(x3),MEM_WB; one retire pulse; reg_wr=1, mem2reg=0.
//   2. R-type, then addi, mem_ready tied 1
//      -> 4 cycles each; reg_dst 1 then 0 in ALU_WB; alu_op 10 then 00.
//   3. beq then bne -> BRANCH asserts pc_wr_beq=1 only, then pc_wr_bne=1 only; pc_src=01; 3 cycles each.
//   4. Opcode 111111 in DECODE -> TRAP next cycle, trap=1, trap_cause=01; held until reset.
//   5. MEM_TIMEOUT=15, sw with mem_ready held 0 -> TRAP after 15 wait cycles, cause 10;
//      repeat with mem_ready on cycle 15 -> no trap, retire=1.
//   6. Assert reset while in MEM_RD -> mem_req=0 same cycle, state IDLE, trap_cause=00.

Source files
------------

// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : mips_pkg
//  Description : Shared encodings for the multi-cycle MIPS control path:
//                opcodes, ALU operation codes, mux select codes, FSM state
//                encoding and trap cause codes.
//  Revision    : 1.0 - initial release
// ============================================================================
package mips_pkg;

    // Opcode field IR[31:26]
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    // ALU operation select
    localparam logic [1:0] ALU_OP_ADD   = 2'b00;
    localparam logic [1:0] ALU_OP_SUB   = 2'b01;
    localparam logic [1:0] ALU_OP_FUNCT = 2'b10;
    localparam logic [1:0] ALU_OP_AND   = 2'b11;

    // ALU B operand select
    localparam logic [1:0] ALU_B_RT      = 2'b00;
    localparam logic [1:0] ALU_B_FOUR    = 2'b01;
    localparam logic [1:0] ALU_B_IMM     = 2'b10;
    localparam logic [1:0] ALU_B_IMM_SH2 = 2'b11;

    // PC source select
    localparam logic [1:0] PC_SRC_ALU    = 2'b00;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

    // Trap cause codes
    localparam logic [1:0] TRAP_NONE    = 2'b00;
    localparam logic [1:0] TRAP_ILLEGAL = 2'b01;
    localparam logic [1:0] TRAP_TIMEOUT = 2'b10;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_FETCH    = 4'd1,
        ST_DECODE   = 4'd2,
        ST_MEM_ADDR = 4'd3,
        ST_MEM_RD   = 4'd4,
        ST_MEM_WB   = 4'd5,
        ST_MEM_WR   = 4'd6,
        ST_R_EXEC   = 4'd7,
        ST_I_EXEC   = 4'd8,
        ST_ALU_WB   = 4'd9,
        ST_BRANCH   = 4'd10,
        ST_JUMP     = 4'd11,
        ST_TRAP     = 4'd12
    } state_t;

endpackage
`default_nettype wire

// File: rtl/mem_wait_timer.sv
`default_nettype none
// ============================================================================
//  Module      : mem_wait_timer
//  Description : Counts cycles a memory request has been outstanding and
//                flags a timeout when the count reaches MEM_TIMEOUT while the
//                memory is still not ready.
//  Ports       : clk, reset (async, active-high)
//                req      - memory request currently asserted
//                ready    - memory completes the access this cycle
//                timeout  - access has waited MEM_TIMEOUT cycles, not ready
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_wait_timer #(
    parameter int MEM_TIMEOUT = 15,  // 0 disables the timeout
    parameter int CNT_W       = 4    // 2**CNT_W must exceed MEM_TIMEOUT
) (
    input  logic clk,
    input  logic reset,
    input  logic req,
    input  logic ready,
    output logic timeout
);

    logic [CNT_W-1:0] wait_cnt;

    // Every exit from a memory state is through ready (or a trap, which drops
    // req), so clearing on !req or ready also clears on entry to the next
    // memory state, including FETCH directly after MEM_WR.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt <= '0;
        end else if (!req || ready) begin
            wait_cnt <= '0;
        end else if (!timeout) begin
            wait_cnt <= wait_cnt + CNT_W'(1);
        end
    end

    // ready in the same cycle takes priority over the timeout.
    assign timeout = (MEM_TIMEOUT != 0) && req && !ready
                     && (wait_cnt == CNT_W'(MEM_TIMEOUT));

endmodule
`default_nettype wire

// File: rtl/multicycle_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_ctrl
//  Description : Moore FSM sequencing a shared-memory multi-cycle MIPS
//                datapath (R-type, lw, sw, beq, bne, j, addi, andi). Traps on
//                an illegal opcode or a memory access timeout.
//  Ports       : clk, reset (async, active-high)
//                opcode     - IR[31:26]
//                mem_ready  - memory completes current access
//                mem_req/mem_wr/iord          - memory port control
//                ir_wr/pc_wr/pc_wr_beq/pc_wr_bne/pc_src - IR and PC update
//                alu_src_a/alu_src_b/alu_op   - ALU operand and op select
//                reg_wr/reg_dst/mem2reg       - register file write control
//                retire     - pulse on final cycle of each instruction
//                trap/trap_cause              - sticky trap status
//  Revision    : 1.0 - initial release
// ============================================================================
module multicycle_ctrl
    import mips_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_wr,
    output logic       iord,
    output logic       ir_wr,
    output logic       pc_wr,
    output logic       pc_wr_beq,
    output logic       pc_wr_bne,
    output logic [1:0] pc_src,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic       reg_wr,
    output logic       reg_dst,
    output logic       mem2reg,
    output logic       retire,
    output logic       trap,
    output logic [1:0] trap_cause
);

    state_t     state;
    state_t     state_nxt;
    logic [1:0] cause;
    logic       dst_rd;    // ALU_WB destination: 1 = rd (R-type), 0 = rt
    logic       is_store;  // captured in DECODE so MEM_ADDR need not read opcode
    logic       timeout;

    mem_wait_timer #(
        .MEM_TIMEOUT (MEM_TIMEOUT),
        .CNT_W       (CNT_W)
    ) u_wait_timer (
        .clk     (clk),
        .reset   (reset),
        .req     (mem_req),
        .ready   (mem_ready),
        .timeout (timeout)
    );

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:     state_nxt = ST_FETCH;
            ST_FETCH: begin
                if (mem_ready)    state_nxt = ST_DECODE;
                else if (timeout) state_nxt = ST_TRAP;
            end
            ST_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW:     state_nxt = ST_MEM_ADDR;
                    OP_RTYPE:         state_nxt = ST_R_EXEC;
                    OP_BEQ, OP_BNE:   state_nxt = ST_BRANCH;
                    OP_J:             state_nxt = ST_JUMP;
                    OP_ADDI, OP_ANDI: state_nxt = ST_I_EXEC;
                    default:          state_nxt = ST_TRAP;
                endcase
            end
            ST_MEM_ADDR: state_nxt = is_store ? ST_MEM_WR : ST_MEM_RD;
            ST_MEM_RD: begin
                if (mem_ready)    state_nxt = ST_MEM_WB;
                else if (timeout) state_nxt = ST_TRAP;
            end
            ST_MEM_WR: begin
                if (mem_ready)    state_nxt = ST_FETCH;
                else if (timeout) state_nxt = ST_TRAP;
            end
            ST_MEM_WB:   state_nxt = ST_FETCH;
            ST_R_EXEC:   state_nxt = ST_ALU_WB;
            ST_I_EXEC:   state_nxt = ST_ALU_WB;
            ST_ALU_WB:   state_nxt = ST_FETCH;
            ST_BRANCH:   state_nxt = ST_FETCH;
            ST_JUMP:     state_nxt = ST_FETCH;
            ST_TRAP:     state_nxt = ST_TRAP;
            default:     state_nxt = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // State and side registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            cause    <= TRAP_NONE;
            dst_rd   <= 1'b0;
            is_store <= 1'b0;
        end else begin
            state <= state_nxt;
            // The only trap from DECODE is an illegal opcode; every other
            // entry comes from a memory state timing out.
            if (state_nxt == ST_TRAP && state != ST_TRAP) begin
                cause <= (state == ST_DECODE) ? TRAP_ILLEGAL : TRAP_TIMEOUT;
            end
            if (state == ST_DECODE) is_store <= (opcode == OP_SW);
            if (state == ST_R_EXEC) dst_rd <= 1'b1;
            if (state == ST_I_EXEC) dst_rd <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Output decode (state only, except the mem_ready-qualified strobes)
    // ------------------------------------------------------------------
    always_comb begin
        mem_req    = 1'b0;
        mem_wr     = 1'b0;
        iord       = 1'b0;
        ir_wr      = 1'b0;
        pc_wr      = 1'b0;
        pc_wr_beq  = 1'b0;
        pc_wr_bne  = 1'b0;
        pc_src     = PC_SRC_ALU;
        alu_src_a  = 1'b0;
        alu_src_b  = ALU_B_RT;
        alu_op     = ALU_OP_ADD;
        reg_wr     = 1'b0;
        reg_dst    = 1'b0;
        mem2reg    = 1'b0;
        retire     = 1'b0;
        trap       = 1'b0;
        trap_cause = cause;
        case (state)
            ST_FETCH: begin
                mem_req   = 1'b1;
                alu_src_b = ALU_B_FOUR;
                ir_wr     = mem_ready;
                pc_wr     = mem_ready;
            end
            ST_DECODE: begin
                alu_src_b = ALU_B_IMM_SH2;  // ALUOut = branch target
            end
            ST_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = ALU_B_IMM;
            end
            ST_MEM_RD: begin
                mem_req = 1'b1;
                iord    = 1'b1;
            end
            ST_MEM_WB: begin
                reg_wr = 1'b1;
                retire = 1'b1;
            end
            ST_MEM_WR: begin
                mem_req = 1'b1;
                mem_wr  = 1'b1;
                iord    = 1'b1;
                retire  = mem_ready;
            end
            ST_R_EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = ALU_B_RT;
                alu_op    = ALU_OP_FUNCT;
            end
            ST_I_EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = ALU_B_IMM;
                alu_op    = (opcode == OP_ANDI) ? ALU_OP_AND : ALU_OP_ADD;
            end
            ST_ALU_WB: begin
                reg_wr  = 1'b1;
                reg_dst = dst_rd;
                mem2reg = 1'b1;
                retire  = 1'b1;
            end
            ST_BRANCH: begin
                alu_src_a = 1'b1;
                alu_src_b = ALU_B_RT;
                alu_op    = ALU_OP_SUB;
                pc_src    = PC_SRC_ALUOUT;
                pc_wr_beq = (opcode == OP_BEQ);
                pc_wr_bne = (opcode == OP_BNE);
                retire    = 1'b1;
            end
            ST_JUMP: begin
                pc_src = PC_SRC_JUMP;
                pc_wr  = 1'b1;
                retire = 1'b1;
            end
            ST_TRAP: begin
                trap = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule
`default_nettype wire
